// File: rtl/seq_mult_addshift_if.sv
// Handshake and operand/product bundle for the sequential add-shift multiplier.
// The master side drives the request and operands; the slave side returns status and product.
interface seq_mult_addshift_if #(
  parameter int WIDTH = 8
);
  logic                   start;
  logic [WIDTH-1:0]       mcand;
  logic [WIDTH-1:0]       mplier;
  logic                   busy;
  logic                   done;
  logic                   x_bit;
  logic [2*WIDTH-1:0]     prod;

  modport master (
    output start, mcand, mplier,
    input  busy, done, x_bit, prod
  );

  modport slave (
    input  start, mcand, mplier,
    output busy, done, x_bit, prod
  );
endinterface

// File: rtl/seq_mult_addshift.sv
// Sequential add-shift multiplier: one (WIDTH+1)-bit add or subtract per bit, then a shift of {X,A,B}.
// Signed mode subtracts on the last step so the multiplier sign bit carries negative weight.
module seq_mult_addshift #(
  parameter int WIDTH       = 8,
  parameter int SIGNED_MODE = 1
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  seq_mult_addshift_if.slave   bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam bit SGN   = (SIGNED_MODE != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  s_reg, s_next;
  logic [WIDTH-1:0]  a_reg, a_next;
  logic [WIDTH-1:0]  b_reg, b_next;
  logic              x_reg, x_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  logic [WIDTH:0]    addend_a;
  logic [WIDTH:0]    addend_s;
  logic [WIDTH:0]    sum;
  logic              last_step;

  // Extend to WIDTH+1 bits: sign-extend in signed mode, zero-extend otherwise.
  assign addend_a  = {(SGN & a_reg[WIDTH-1]), a_reg};
  assign addend_s  = {(SGN & s_reg[WIDTH-1]), s_reg};
  assign last_step = (cnt_reg == CNT_LAST);
  assign sum       = (SGN && last_step) ? (addend_a - addend_s) : (addend_a + addend_s);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      x_reg     <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      x_reg     <= x_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    x_next     = x_reg;
    cnt_next   = cnt_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          s_next     = bus.mcand;
          b_next     = bus.mplier;
          a_next     = '0;
          x_next     = 1'b0;
          cnt_next   = '0;
          state_next = ADD;
        end
      end

      ADD: begin
        if (b_reg[0]) begin
          {x_next, a_next} = sum;
        end
        state_next = SHIFT;
      end

      SHIFT: begin
        // X replicates into A's MSB; in signed mode it also stays as the sign extension.
        x_next = SGN ? x_reg : 1'b0;
        a_next = {x_reg, a_reg[WIDTH-1:1]};
        b_next = {a_reg[0], b_reg[WIDTH-1:1]};
        if (last_step) begin
          state_next = DONE;
        end else begin
          cnt_next   = cnt_reg + CNT_W'(1);
          state_next = ADD;
        end
      end

      DONE: begin
        // Start must drop before a new operation can be accepted.
        if (!bus.start) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.busy  = (state_reg == ADD) || (state_reg == SHIFT);
  assign bus.done  = (state_reg == DONE);
  assign bus.prod  = {a_reg, b_reg};
  assign bus.x_bit = x_reg;

endmodule
